// File: rtl/truth_table_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : truth_table_seq_pkg
// Brief  : Shared types and constants for the truth-table sequencer and the
//          gate datapath it checks.
// Rev    : 1.0  initial release
// ============================================================================
package truth_table_seq_pkg;

   localparam int TTS_NUM_VECTORS = 16;
   localparam int TTS_RESULT_W    = 7;
   localparam int TTS_STIM_W      = 4;
   localparam int TTS_ERR_W       = 5;

   // Result bit positions, LED order, shared with the gate datapath.
   localparam int TTS_BIT_AND     = 0;
   localparam int TTS_BIT_OR      = 1;
   localparam int TTS_BIT_XOR     = 2;
   localparam int TTS_BIT_NAND    = 3;
   localparam int TTS_BIT_DM_OR   = 4;
   localparam int TTS_BIT_MAJ     = 5;
   localparam int TTS_BIT_ONE_HOT = 6;

   typedef enum logic [2:0] {
      TTS_IDLE   = 3'd0,
      TTS_APPLY  = 3'd1,
      TTS_SETTLE = 3'd2,
      TTS_CHECK  = 3'd3,
      TTS_WAIT   = 3'd4,
      TTS_DONE   = 3'd5
   } tts_state_t;

endpackage
`default_nettype wire

// File: rtl/truth_table_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : truth_table_sequencer_if
// Brief  : Control, stimulus and status bundle between the board top / gate
//          datapath (master) and the truth-table sequencer (slave).
// Rev    : 1.0  initial release
// ============================================================================
interface truth_table_sequencer_if;

   logic                                       start;
   logic                                       step;
   logic [truth_table_seq_pkg::TTS_STIM_W-1:0]   stim;
   logic [truth_table_seq_pkg::TTS_RESULT_W-1:0] dut_result;
   logic                                       busy;
   logic                                       done;
   logic                                       pass;
   logic [truth_table_seq_pkg::TTS_ERR_W-1:0]    err_count;
   logic [truth_table_seq_pkg::TTS_STIM_W-1:0]   fail_vec;
   logic                                       fail_valid;

   modport master (
      output start, step, dut_result,
      input  stim, busy, done, pass, err_count, fail_vec, fail_valid
   );

   modport slave (
      input  start, step, dut_result,
      output stim, busy, done, pass, err_count, fail_vec, fail_valid
   );

endinterface
`default_nettype wire

// File: rtl/gate_golden_model.sv
`default_nettype none
// ============================================================================
// Module : gate_golden_model
// Brief  : Combinational reference for the gate / De Morgan datapath; the
//          whole result is forced to zero while EN is low.
// Rev    : 1.0  initial release
// ============================================================================
module gate_golden_model
   import truth_table_seq_pkg::*;
(
   input  wire logic [TTS_STIM_W-1:0]   stim,
   output logic      [TTS_RESULT_W-1:0] expected
);

   logic w_a;
   logic w_b;
   logic w_c;
   logic w_en;

   assign w_a  = stim[0];
   assign w_b  = stim[1];
   assign w_c  = stim[2];
   assign w_en = stim[3];

   always_comb begin
      expected = '0;
      if (w_en) begin
         expected[TTS_BIT_AND]     = w_a & w_b;
         expected[TTS_BIT_OR]      = w_a | w_b;
         expected[TTS_BIT_XOR]     = w_a ^ w_b;
         expected[TTS_BIT_NAND]    = ~(w_a & w_b);
         expected[TTS_BIT_DM_OR]   = ~w_a | ~w_b;
         expected[TTS_BIT_MAJ]     = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
         expected[TTS_BIT_ONE_HOT] = (w_a ^ w_b ^ w_c) & ~(w_a & w_b & w_c);
      end
   end

endmodule
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module : truth_table_sequencer
// Brief  : Walks all 16 {EN,C,B,A} vectors, settles, and checks the gate
//          datapath result against gate_golden_model.
//          Option macro: TRUTH_TABLE_SEQ_STOP_ON_FAIL_EN (halt on first miss).
// Rev    : 1.0  initial release
// ============================================================================
module truth_table_sequencer
   import truth_table_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)
(
   input  wire logic               clock,
   input  wire logic               reset,
   truth_table_sequencer_if.slave  bus
);

   localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_settle_load =
      c_cnt_w'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
   localparam logic [TTS_STIM_W-1:0] c_last_idx = TTS_STIM_W'(TTS_NUM_VECTORS - 1);

   tts_state_t              r_state;
   logic [TTS_STIM_W-1:0]   r_idx;
   logic [c_cnt_w-1:0]      r_cnt;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_pass;
   logic [TTS_ERR_W-1:0]    r_err_count;
   logic [TTS_STIM_W-1:0]   r_fail_vec;
   logic                    r_fail_valid;

   logic [TTS_RESULT_W-1:0] w_expected;
   logic                    w_mismatch;

   gate_golden_model u_golden (
      .stim     (r_idx),
      .expected (w_expected)
   );

   assign w_mismatch = (bus.dut_result != w_expected);

   // The vector index doubles as the registered stimulus.
   assign bus.stim       = r_idx;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.pass       = r_pass;
   assign bus.err_count  = r_err_count;
   assign bus.fail_vec   = r_fail_vec;
   assign bus.fail_valid = r_fail_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= TTS_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_count  <= '0;
         r_fail_vec   <= '0;
         r_fail_valid <= 1'b0;
      end else begin
         case (r_state)
            TTS_IDLE, TTS_DONE: begin
               if (bus.start) begin
                  r_state      <= TTS_APPLY;
                  r_idx        <= '0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
                  r_err_count  <= '0;
                  r_fail_vec   <= '0;
                  r_fail_valid <= 1'b0;
               end
            end

            TTS_APPLY: begin
               if (SETTLE_CYCLES > 0) begin
                  r_state <= TTS_SETTLE;
                  r_cnt   <= c_settle_load;
               end else begin
                  r_state <= TTS_CHECK;
               end
            end

            TTS_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= TTS_CHECK;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            TTS_CHECK: begin
               r_state <= TTS_WAIT;
               if (w_mismatch) begin
                  r_err_count <= r_err_count + 1'b1;
                  if (!r_fail_valid) begin
                     r_fail_vec   <= r_idx;
                     r_fail_valid <= 1'b1;
                  end
`ifdef TRUTH_TABLE_SEQ_STOP_ON_FAIL_EN
                  // First miss ends the run with stim frozen on the bad vector.
                  r_state <= TTS_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= 1'b0;
`endif
               end
            end

            TTS_WAIT: begin
               if (bus.step) begin
                  if (r_idx == c_last_idx) begin
                     r_state <= TTS_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (r_err_count == '0);
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= TTS_APPLY;
                  end
               end
            end

            default: begin
               r_state <= TTS_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_truth_table_sequencer
// Brief  : Randomized self-checking bench; a bench-side datapath with
//          injectable faults feeds the sequencer and a reference predicts.
// Rev    : 1.0  initial release
// ============================================================================
module tb_truth_table_sequencer;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_total = 0;
   int n_bad   = 0;

   int       mode = 0;   // 0 good, 1 bit2 stuck-0, 2 EN ignored, 3 xor mask
   logic [6:0] masks [16];

   logic [3:0] d0, d1, d2;
   logic [3:0] dz;

   truth_table_sequencer_if bif ();
   truth_table_sequencer_if zif ();

   truth_table_sequencer #(.SETTLE_CYCLES(2)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   truth_table_sequencer #(.SETTLE_CYCLES(0)) u_dut_zero (
      .clock (clock),
      .reset (reset),
      .bus   (zif)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] spec_out(input logic [3:0] v);
      int a, b, c, ones;
      logic [6:0] r;
      a    = int'(v[0]);
      b    = int'(v[1]);
      c    = int'(v[2]);
      ones = a + b + c;
      r    = '0;
      if (v[3]) begin
         r[0] = (a + b == 2);
         r[1] = (a + b >= 1);
         r[2] = (a + b == 1);
         r[3] = !(a + b == 2);
         r[4] = (a == 0) || (b == 0);
         r[5] = (ones >= 2);
         r[6] = (ones == 1);
      end
      return r;
   endfunction

   function automatic logic [6:0] datapath(input logic [3:0] v, input int m, input logic [6:0] msk);
      logic [6:0] r;
      case (m)
         1:       r = spec_out(v) & 7'b111_1011;
         2:       r = spec_out({1'b1, v[2:0]});
         3:       r = spec_out(v) ^ msk;
         default: r = spec_out(v);
      endcase
      return r;
   endfunction

   // Result becomes valid exactly SETTLE_CYCLES+1 cycles after stim changes.
   always @(posedge clock) begin
      d0 <= bif.stim;
      d1 <= d0;
      d2 <= d1;
      dz <= zif.stim;
   end

   always_comb bif.dut_result = datapath(d2, mode, masks[d2]);
   always_comb zif.dut_result = spec_out(dz);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic predict(output int e, output int fv);
      e  = 0;
      fv = 0;
      for (int v = 0; v < 16; v++) begin
         if (datapath(4'(v), mode, masks[v]) != spec_out(4'(v))) begin
            if (e == 0) fv = v;
            e++;
         end
      end
   endtask

   task automatic kick();
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      chk("kick_stim", 32'(bif.stim), 0);
      chk("kick_busy", 32'(bif.busy), 1);
      chk("kick_done", 32'(bif.done), 0);
   endtask

   // gap_mode: 0 step every 5 cycles, 1 random gaps, 2 step held high
   task automatic finish_run(input string tag, input int gap_mode, input int exp_cycles);
      int e, fv, cyc, gap, ee, es;
      predict(e, fv);
      cyc = 0;
      gap = 0;
      while (!bif.done && cyc < 3000) begin
         case (gap_mode)
            0: bif.step = (cyc % 5 == 4);
            1: begin
               if (gap == 0) begin
                  bif.step = 1'b1;
                  gap = int'($urandom_range(1, 6));
               end else begin
                  bif.step = 1'b0;
                  gap--;
               end
            end
            default: bif.step = 1'b1;
         endcase
         tick();
         cyc++;
      end
      bif.step = 1'b0;
`ifdef TRUTH_TABLE_SEQ_STOP_ON_FAIL_EN
      ee = (e > 0) ? 1 : 0;
      es = (e > 0) ? fv : 15;
`else
      ee = e;
      es = 15;
`endif
      chk({tag, "_done"}, 32'(bif.done), 1);
      if (exp_cycles > 0) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
      chk({tag, "_err"}, 32'(bif.err_count), 32'(ee));
      chk({tag, "_pass"}, 32'(bif.pass), (e == 0) ? 1 : 0);
      chk({tag, "_fvalid"}, 32'(bif.fail_valid), (e > 0) ? 1 : 0);
      chk({tag, "_fvec"}, 32'(bif.fail_vec), 32'(fv));
      chk({tag, "_stim"}, 32'(bif.stim), 32'(es));
      chk({tag, "_busy"}, 32'(bif.busy), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stim"}, 32'(bif.stim), 0);
      chk({tag, "_busy"}, 32'(bif.busy), 0);
      chk({tag, "_done"}, 32'(bif.done), 0);
      chk({tag, "_pass"}, 32'(bif.pass), 0);
      chk({tag, "_err"}, 32'(bif.err_count), 0);
      chk({tag, "_fvec"}, 32'(bif.fail_vec), 0);
      chk({tag, "_fvalid"}, 32'(bif.fail_valid), 0);
   endtask

   initial begin
      int cyc;
      bit seen;
      bif.start = 1'b0;
      bif.step  = 1'b0;
      zif.start = 1'b0;
      zif.step  = 1'b1;
      for (int i = 0; i < 16; i++) masks[i] = '0;

      tick();
      tick();
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();

      // start and step together in IDLE: start wins, run begins at vector 0
      bif.start = 1'b1;
      bif.step  = 1'b1;
      tick();
      bif.start = 1'b0;
      bif.step  = 1'b0;
      chk("idle_both_stim", 32'(bif.stim), 0);
      chk("idle_both_busy", 32'(bif.busy), 1);
      finish_run("idle_both", 2, 0);

      // golden datapath, step every 5 cycles, then step held high (5-cycle vectors)
      kick();
      finish_run("gold5", 0, 0);
      kick();
      finish_run("goldhi", 2, 80);

      mode = 1;
      kick();
      finish_run("stuck2", 1, 0);

      mode = 2;
      kick();
      finish_run("noen", 1, 0);

      mode = 3;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++)
            masks[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
         kick();
         finish_run("rand", 1, 0);
      end

      // step during APPLY/SETTLE and start while busy are ignored
      mode = 0;
      kick();
      bif.step  = 1'b1;
      bif.start = 1'b1;
      tick();
      tick();
      bif.step  = 1'b0;
      bif.start = 1'b0;
      tick();
      chk("ign_stim", 32'(bif.stim), 0);
      chk("ign_busy", 32'(bif.busy), 1);
      tick();
      chk("ign_wait_stim", 32'(bif.stim), 0);
      bif.step = 1'b1;
      tick();
      bif.step = 1'b0;
      chk("ign_next_stim", 32'(bif.stim), 1);
      finish_run("ign", 2, 0);

      // reset in SETTLE of vector 5
      kick();
      bif.step = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         tick();
         if (bif.stim == 4'd5) seen = 1'b1;
      end
      chk("rst5_reached", 32'(seen), 1);
      bif.step = 1'b0;
      tick();
      #1 reset = 1'b1;
      #1;
      chk_reset_vals("rst5");
      reset = 1'b0;
      tick();
      chk("rst5_idle_busy", 32'(bif.busy), 0);
      kick();
      finish_run("after_rst", 1, 0);

      // zero-settle instance, step tied high: 3-cycle vectors
      zif.start = 1'b1;
      tick();
      zif.start = 1'b0;
      chk("zero_stim", 32'(zif.stim), 0);
      cyc = 0;
      while (!zif.done && cyc < 200) begin
         tick();
         cyc++;
      end
      chk("zero_cycles", 32'(cyc), 48);
      chk("zero_pass", 32'(zif.pass), 1);
      chk("zero_err", 32'(zif.err_count), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
